dual_writeback: RTL
===================

Name: dual_writeback

Overview:
Writeback stage for the dual-issue pipeline; the write side of the dual-port register file that decode reads. It accepts up to two in-order results per cycle from the execute lanes, buffers them in a small in-order queue, and retires up to two per cycle onto the register file's two write ports (write_reg_flag_N / write_reg_N / write_data_N). It resolves same-destination conflicts between the two retiring entries and exports a pending-destination mask for decode hazard checks.

Parameters:
DEPTH, 4, queue entries; power of two, at least 2
DATA_W, 32, result data width
REG_W, 5, register index width (32 registers)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
in_valid_1  input  1  lane 1 result valid (older in program order)
in_reg_1  input  REG_W  lane 1 destination
in_data_1  input  DATA_W  lane 1 result
in_valid_2  input  1  lane 2 result valid (younger)
in_reg_2  input  REG_W  lane 2 destination
in_data_2  input  DATA_W  lane 2 result
in_ready  output  1  at least 2 free entries; results accepted only when high
wb_enable  input  1  retirement permitted this cycle
write_reg_flag_1  output  1  port 1 write strobe
write_reg_1  output  REG_W  port 1 destination
write_data_1  output  DATA_W  port 1 data
write_reg_flag_2  output  1  port 2 write strobe
write_reg_2  output  REG_W  port 2 destination
write_data_2  output  DATA_W  port 2 data
pending_mask  output  32  bit r set while a write to register r is outstanding
count  output  clog2(DEPTH)+1  stored entries
drained  output  1  count==0 and both write strobes low

Behaviour:
- Single clock clk; reset rst_n asynchronous, active-low.
- Reset values: all write_reg_flag_N, write_reg_N, write_data_N = 0; count 0; read/write pointers 0; pending_mask 0; in_ready 1; drained 1. Asserting rst_n mid-operation drops both strobes immediately and discards queue contents. No stale write occurs after release.
- in_ready is combinational from registered count: (DEPTH - count) >= 2.
- Enqueue at a rising edge with in_ready high: lane 1 is stored first, then lane 2, in consecutive slots. A valid lane whose destination is 0 is discarded: it is not stored, uses no slot, and sets no pending bit. Lane 2 alone takes the oldest free slot. Valid lanes offered while in_ready is low are ignored; the producer holds them.
- Retire at a rising edge with wb_enable high. Only entries stored before this edge are eligible.
- count>=2: the head entry goes to port 1 and head+1 to port 2. Both strobes are 1 for exactly one cycle.
- count==1: the head entry goes to port 1; flag 2 is 0.
- count==0 or wb_enable low: both flags are 0; reg/data outputs hold their last values.
- WAW merge: if both retiring entries have the same destination, flag 1 is 0 and flag 2 is 1. The younger write wins, and both entries are still consumed.
- Latency: an entry accepted at edge k drives its write port, earliest, during the cycle after edge k+1.
- Enqueue and retire in the same edge both take effect: count_next = count + enq - ret.
- Pointers wrap modulo DEPTH.
- Write ports are registered outputs. The register file captures them at the next edge.
- pending_mask is combinational: the OR of decoded destinations of all stored entries plus any port whose strobe is high. A bit clears only after the strobe cycle ends.

Test Plan:
- Reset: rst_n low -> both flags 0, count 0, in_ready 1, pending_mask 0, drained 1.
- Dual accept: wb_enable=1; lane1 r3=0x11, lane2 r5=0x22 at edge k -> after edge k+1, port1 r3/0x11 and port2 r5/0x22 with both flags 1 for one cycle. pending_mask is 0x28 from edge k until that cycle ends, then 0.
- WAW: lane1 r7=0xA and lane2 r7=0xB -> retiring cycle has flag1=0, flag2=1, write_reg_2=7, write_data_2=0xB; count returns to 0.
- r0 drop: lane1 r0=0x55, lane2 r4=0x66 -> count 1, pending_mask 0x10; retires on port 1 (r4/0x66) with flag2=0.
- Backpressure and wrap: wb_enable=0; accept pairs (r1,r2) and (r3,r4) -> count 4, in_ready 0. Offer a third pair (r6,r8); it is ignored. Raise wb_enable -> retire (r1,r2) then (r3,r4). in_ready returns to 1 after the first retire. Accept (r6,r8) across the wrap; it retires in order.
- Mid-op reset: count 3 with a strobe high, pull rst_n low -> strobes 0 in the same cycle. After release, count 0, pending_mask 0, and no writes appear over 5 cycles.

Source files
------------

// File: rtl/dual_writeback.sv
// Dual-issue writeback stage: buffers up to two in-order execute results per
// cycle in a small circular queue and retires up to two per cycle onto the
// register file's two write ports. It merges same-destination pairs so that
// the younger write wins, and it exports a mask of registers with writes
// still outstanding so decode can detect hazards.
module dual_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_1,
  input  logic [REG_W-1:0]           in_reg_1,
  input  logic [DATA_W-1:0]          in_data_1,
  input  logic                       in_valid_2,
  input  logic [REG_W-1:0]           in_reg_2,
  input  logic [DATA_W-1:0]          in_data_2,
  output logic                       in_ready,
  input  logic                       wb_enable,
  output logic                       write_reg_flag_1,
  output logic [REG_W-1:0]           write_reg_1,
  output logic [DATA_W-1:0]          write_data_1,
  output logic                       write_reg_flag_2,
  output logic [REG_W-1:0]           write_reg_2,
  output logic [DATA_W-1:0]          write_data_2,
  output logic [31:0]                pending_mask,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drained
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Queue storage and control state
  logic [REG_W-1:0]  mem_reg_q  [DEPTH];
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_inc, wr_ptr_inc;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered write ports
  logic              write_reg_flag_1_q, write_reg_flag_1_d;
  logic [REG_W-1:0]  write_reg_1_q, write_reg_1_d;
  logic [DATA_W-1:0] write_data_1_q, write_data_1_d;
  logic              write_reg_flag_2_q, write_reg_flag_2_d;
  logic [REG_W-1:0]  write_reg_2_q, write_reg_2_d;
  logic [DATA_W-1:0] write_data_2_q, write_data_2_d;

  // Enqueue decode
  logic              keep_1, keep_2;
  logic              slot_a_en, slot_b_en;
  logic [REG_W-1:0]  slot_a_reg;
  logic [DATA_W-1:0] slot_a_data;
  logic [1:0]        enq_num, ret_num;

  assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);
  assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);

  // Two free slots are required so a full pair can always be absorbed.
  assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(2);

  // Select which lanes are stored; writes to r0 are dropped, and lane 2
  // slides into the first slot when lane 1 is absent.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    keep_1      = in_ready && in_valid_1 && (in_reg_1 != '0);
    keep_2      = in_ready && in_valid_2 && (in_reg_2 != '0);
    slot_a_en   = keep_1 || keep_2;
    slot_b_en   = keep_1 && keep_2;
    slot_a_reg  = keep_1 ? in_reg_1  : in_reg_2;
    slot_a_data = keep_1 ? in_data_1 : in_data_2;
    enq_num     = {1'b0, keep_1} + {1'b0, keep_2};
  end

  // Retire up to two head entries and compute next pointer/count state.
  always_comb begin
    write_reg_flag_1_d = 1'b0;
    write_reg_flag_2_d = 1'b0;
    write_reg_1_d      = write_reg_1_q;
    write_data_1_d     = write_data_1_q;
    write_reg_2_d      = write_reg_2_q;
    write_data_2_d     = write_data_2_q;
    ret_num            = 2'd0;
    if (wb_enable && (count_q != '0)) begin
      write_reg_1_d      = mem_reg_q[rd_ptr_q];
      write_data_1_d     = mem_data_q[rd_ptr_q];
      write_reg_flag_1_d = 1'b1;
      ret_num            = 2'd1;
      if (count_q >= CNT_W'(2)) begin
        write_reg_2_d      = mem_reg_q[rd_ptr_inc];
        write_data_2_d     = mem_data_q[rd_ptr_inc];
        write_reg_flag_2_d = 1'b1;
        ret_num            = 2'd2;
        // Same destination: only the younger write reaches the register file.
        if (mem_reg_q[rd_ptr_inc] == mem_reg_q[rd_ptr_q]) begin
          write_reg_flag_1_d = 1'b0;
        end
      end
    end
    rd_ptr_d = rd_ptr_q + PTR_W'(ret_num);
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_num);
    count_d  = count_q + CNT_W'(enq_num) - CNT_W'(ret_num);
  end

  // Control state and write-port registers; reset drops strobes at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      rd_ptr_q           <= '0;
      wr_ptr_q           <= '0;
      count_q            <= '0;
      write_reg_flag_1_q <= 1'b0;
      write_reg_1_q      <= '0;
      write_data_1_q     <= '0;
      write_reg_flag_2_q <= 1'b0;
      write_reg_2_q      <= '0;
      write_data_2_q     <= '0;
    end else begin
      rd_ptr_q           <= rd_ptr_d;
      wr_ptr_q           <= wr_ptr_d;
      count_q            <= count_d;
      write_reg_flag_1_q <= write_reg_flag_1_d;
      write_reg_1_q      <= write_reg_1_d;
      write_data_1_q     <= write_data_1_d;
      write_reg_flag_2_q <= write_reg_flag_2_d;
      write_reg_2_q      <= write_reg_2_d;
      write_data_2_q     <= write_data_2_d;
    end
  end

  // Queue storage writes for accepted lanes, in consecutive slots.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; occupancy is tracked by count_q
    // and pointers, so stale contents are never observed.
    if (slot_a_en) begin
      mem_reg_q[wr_ptr_q]  <= slot_a_reg;
      mem_data_q[wr_ptr_q] <= slot_a_data;
    end
    if (slot_b_en) begin
      mem_reg_q[wr_ptr_inc]  <= in_reg_2;
      mem_data_q[wr_ptr_inc] <= in_data_2;
    end
  end

  // Outstanding destinations: every occupied slot plus any live strobe.
  always_comb begin
    logic [PTR_W-1:0] offset;
    pending_mask = '0;
    offset       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if ({1'b0, offset} < count_q) begin
        pending_mask = pending_mask | (32'(1) << mem_reg_q[i]);
      end
    end
    if (write_reg_flag_1_q) pending_mask = pending_mask | (32'(1) << write_reg_1_q);
    if (write_reg_flag_2_q) pending_mask = pending_mask | (32'(1) << write_reg_2_q);
  end

  assign write_reg_flag_1 = write_reg_flag_1_q;
  assign write_reg_1      = write_reg_1_q;
  assign write_data_1     = write_data_1_q;
  assign write_reg_flag_2 = write_reg_flag_2_q;
  assign write_reg_2      = write_reg_2_q;
  assign write_data_2     = write_data_2_q;
  assign count            = count_q;
  assign drained          = (count_q == '0) && !write_reg_flag_1_q && !write_reg_flag_2_q;

endmodule
